// File: rtl/keypad_scanner.sv
// Column-scanning, debounced 4x4 keypad reader (Pmod KYPD layout).
// Emits the accepted key code plus a level press flag for the calculator control unit.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] button,
    output logic       is_pressed,
    output logic       frame_tick
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        RES_NONE,
        RES_KEY,
        RES_MULTI
    } result_t;

    logic [3:0]    r_rowMeta;
    logic [3:0]    r_rowSync;
    logic [DW-1:0] r_dwellCnt;
    logic [1:0]    r_colIdx;
    logic [3:0]    r_snap0;
    logic [3:0]    r_snap1;
    logic [3:0]    r_snap2;
    result_t       r_candKind;
    logic [3:0]    r_candCode;
    logic [CW-1:0] r_stableCnt;
    logic [3:0]    r_button;
    logic          r_pressed;
    logic          r_frameTick;
    logic          r_repress;

    logic          w_lastDwell;
    logic          w_frameEnd;
    logic [15:0]   w_map;
    logic [4:0]    w_hits;
    logic [3:0]    w_code;
    result_t       w_kind;
    result_t       w_nextKind;
    logic [3:0]    w_nextCode;
    logic [CW-1:0] w_nextStable;
    logic          w_accept;

    function automatic logic [3:0] keyCode(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: keyCode = 4'h1;
            4'h1: keyCode = 4'h2;
            4'h2: keyCode = 4'h3;
            4'h3: keyCode = 4'hA;
            4'h4: keyCode = 4'h4;
            4'h5: keyCode = 4'h5;
            4'h6: keyCode = 4'h6;
            4'h7: keyCode = 4'hB;
            4'h8: keyCode = 4'h7;
            4'h9: keyCode = 4'h8;
            4'hA: keyCode = 4'h9;
            4'hB: keyCode = 4'hC;
            4'hC: keyCode = 4'h0;
            4'hD: keyCode = 4'hF;
            4'hE: keyCode = 4'hE;
            default: keyCode = 4'hD;
        endcase
    endfunction

    assign w_lastDwell = (r_dwellCnt == DWELL_LAST);
    assign w_frameEnd  = w_lastDwell && (r_colIdx == 2'd3);

    // Column 3 is evaluated straight from the synchronizer so the result lands with frame_tick.
    assign w_map = {~r_rowSync, r_snap2, r_snap1, r_snap0};

    always_comb begin
        w_hits = '0;
        w_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (w_map[i]) begin
                w_hits = w_hits + 5'd1;
                w_code = keyCode(2'(i % 4), 2'(i / 4));
            end
        end
        if (w_hits == 5'd0)      w_kind = RES_NONE;
        else if (w_hits == 5'd1) w_kind = RES_KEY;
        else                     w_kind = RES_MULTI;
    end

    always_comb begin
        w_nextKind   = r_candKind;
        w_nextCode   = r_candCode;
        w_nextStable = r_stableCnt;
        if (w_kind == RES_MULTI) begin
            w_nextStable = '0;
        end else if (w_kind == r_candKind && (w_kind == RES_NONE || w_code == r_candCode)) begin
            if (r_stableCnt != STABLE_MAX) w_nextStable = r_stableCnt + 1'b1;
        end else begin
            w_nextKind   = w_kind;
            w_nextCode   = w_code;
            w_nextStable = CW'(1);
        end
        w_accept = (w_kind != RES_MULTI) && (w_nextStable == STABLE_MAX);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rowMeta   <= '0;
            r_rowSync   <= '0;
            r_dwellCnt  <= '0;
            r_colIdx    <= '0;
            r_snap0     <= '0;
            r_snap1     <= '0;
            r_snap2     <= '0;
            r_candKind  <= RES_NONE;
            r_candCode  <= '0;
            r_stableCnt <= '0;
            r_button    <= '0;
            r_pressed   <= 1'b0;
            r_frameTick <= 1'b0;
            r_repress   <= 1'b0;
        end else begin
            r_rowMeta   <= row;
            r_rowSync   <= r_rowMeta;
            r_frameTick <= w_frameEnd;
            r_repress   <= 1'b0;
            if (r_repress) r_pressed <= 1'b1;

            if (w_lastDwell) begin
                r_dwellCnt <= '0;
                r_colIdx   <= r_colIdx + 2'd1;
                case (r_colIdx)
                    2'd0:    r_snap0 <= ~r_rowSync;
                    2'd1:    r_snap1 <= ~r_rowSync;
                    2'd2:    r_snap2 <= ~r_rowSync;
                    default: ;
                endcase
            end else begin
                r_dwellCnt <= r_dwellCnt + 1'b1;
            end

            if (w_frameEnd) begin
                r_candKind  <= w_nextKind;
                r_candCode  <= w_nextCode;
                r_stableCnt <= w_nextStable;
                if (w_accept) begin
                    if (w_nextKind == RES_NONE) begin
                        r_pressed <= 1'b0;
                    end else if (!r_pressed) begin
                        r_button  <= w_nextCode;
                        r_pressed <= 1'b1;
                    end else if (w_nextCode != r_button) begin
                        // Drop for one cycle so the downstream edge detector sees a new press.
                        r_button  <= w_nextCode;
                        r_pressed <= 1'b0;
                        r_repress <= 1'b1;
                    end
                end
            end
        end
    end

    assign col        = ~(4'b0001 << r_colIdx);
    assign button     = r_button;
    assign is_pressed = r_pressed;
    assign frame_tick = r_frameTick;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model pulls rows low for pressed keys on the driven column.
// Small scan/debounce settings keep every expectation hand-countable in frames.
module tb_keypad_scanner;

    localparam logic [15:0] K1 = 16'h0001;
    localparam logic [15:0] K2 = 16'h0002;
    localparam logic [15:0] KA = 16'h0008;
    localparam logic [15:0] K5 = 16'h0020;
    localparam logic [15:0] K7 = 16'h0100;
    localparam logic [15:0] KC = 16'h0800;
    localparam logic [15:0] KE = 16'h4000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  button;
    logic        is_pressed;
    logic        frame_tick;
    logic [15:0] keys = '0;
    int          checkCount = 0;
    int          passCount = 0;
    bit          sawPress;

    always #5 clock = ~clock;

    // Key (r,c) lives at bit r*4+c; it shorts row r low while column c is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
    end

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_FRAMES(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .row(row),
        .col(col),
        .button(button),
        .is_pressed(is_pressed),
        .frame_tick(frame_tick)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic nextTick();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_tick && n < 40);
        checkOutput("frame_tick_seen", 32'(frame_tick), 32'd1);
    endtask

    task automatic applyStimulus(input logic [15:0] k);
        keys = k;
    endtask

    initial begin
        $display("[TB] keypad_scanner directed run");

        waitCycles(5);
        checkOutput("rst_col", 32'(col), 32'hE);
        checkOutput("rst_button", 32'(button), 32'h0);
        checkOutput("rst_pressed", 32'(is_pressed), 32'h0);
        checkOutput("rst_tick", 32'(frame_tick), 32'h0);
        reset = 1'b1;
        waitCycles(4);
        checkOutput("col1", 32'(col), 32'hD);
        waitCycles(4);
        checkOutput("col2", 32'(col), 32'hB);
        waitCycles(4);
        checkOutput("col3", 32'(col), 32'h7);
        waitCycles(4);
        checkOutput("col0_wrap", 32'(col), 32'hE);
        checkOutput("tick_first", 32'(frame_tick), 32'h1);
        waitCycles(1);
        checkOutput("tick_pulse_end", 32'(frame_tick), 32'h0);
        waitCycles(15);
        checkOutput("tick_period", 32'(frame_tick), 32'h1);

        applyStimulus(K5);
        nextTick();
        checkOutput("k5_f1", 32'(is_pressed), 32'h0);
        nextTick();
        checkOutput("k5_f2", 32'(is_pressed), 32'h0);
        nextTick();
        checkOutput("k5_f3_pressed", 32'(is_pressed), 32'h1);
        checkOutput("k5_f3_button", 32'(button), 32'h5);
        for (int f = 0; f < 7; f++) begin
            nextTick();
            checkOutput("k5_hold", 32'(is_pressed), 32'h1);
        end
        applyStimulus('0);
        nextTick();
        nextTick();
        checkOutput("k5_rel_f2", 32'(is_pressed), 32'h1);
        nextTick();
        checkOutput("k5_rel_f3", 32'(is_pressed), 32'h0);
        checkOutput("k5_rel_button", 32'(button), 32'h5);

        reset = 1'b0;
        waitCycles(1);
        checkOutput("rst2_button", 32'(button), 32'h0);
        reset = 1'b1;
        sawPress = 1'b0;
        for (int t = 0; t < 13; t++) begin
            applyStimulus(keys ^ K7);
            repeat (5) begin
                @(negedge clock);
                if (is_pressed) sawPress = 1'b1;
            end
        end
        applyStimulus('0);
        repeat (4) nextTick();
        checkOutput("bounce_never", 32'(sawPress), 32'h0);
        checkOutput("bounce_pressed", 32'(is_pressed), 32'h0);
        checkOutput("bounce_button", 32'(button), 32'h0);

        applyStimulus(KA);
        nextTick();
        nextTick();
        checkOutput("kA_f2", 32'(is_pressed), 32'h0);
        nextTick();
        checkOutput("kA_pressed", 32'(is_pressed), 32'h1);
        checkOutput("kA_button", 32'(button), 32'hA);
        applyStimulus(KC);
        nextTick();
        checkOutput("slide_f1_button", 32'(button), 32'hA);
        nextTick();
        checkOutput("slide_f2_pressed", 32'(is_pressed), 32'h1);
        nextTick();
        checkOutput("slide_gap_pressed", 32'(is_pressed), 32'h0);
        checkOutput("slide_gap_button", 32'(button), 32'hC);
        waitCycles(1);
        checkOutput("slide_repress", 32'(is_pressed), 32'h1);
        checkOutput("slide_button", 32'(button), 32'hC);
        waitCycles(1);
        checkOutput("slide_hold", 32'(is_pressed), 32'h1);

        nextTick();
        applyStimulus('0);
        repeat (3) nextTick();
        checkOutput("kC_release", 32'(is_pressed), 32'h0);
        applyStimulus(K1 | K2);
        for (int f = 0; f < 6; f++) begin
            nextTick();
            checkOutput("multi_pressed", 32'(is_pressed), 32'h0);
        end
        checkOutput("multi_button", 32'(button), 32'hC);
        applyStimulus(K1);
        nextTick();
        nextTick();
        checkOutput("k1_f2", 32'(is_pressed), 32'h0);
        nextTick();
        checkOutput("k1_pressed", 32'(is_pressed), 32'h1);
        checkOutput("k1_button", 32'(button), 32'h1);

        applyStimulus('0);
        repeat (3) nextTick();
        checkOutput("k1_release", 32'(is_pressed), 32'h0);
        applyStimulus(KE);
        repeat (3) nextTick();
        checkOutput("kE_pressed", 32'(is_pressed), 32'h1);
        checkOutput("kE_button", 32'(button), 32'hE);
        waitCycles(7);
        reset = 1'b0;
        waitCycles(1);
        checkOutput("midrst_button", 32'(button), 32'h0);
        checkOutput("midrst_pressed", 32'(is_pressed), 32'h0);
        checkOutput("midrst_col", 32'(col), 32'hE);
        checkOutput("midrst_tick", 32'(frame_tick), 32'h0);
        reset = 1'b1;
        nextTick();
        checkOutput("kE_re_f1", 32'(is_pressed), 32'h0);
        nextTick();
        checkOutput("kE_re_f2", 32'(is_pressed), 32'h0);
        nextTick();
        checkOutput("kE_re_pressed", 32'(is_pressed), 32'h1);
        checkOutput("kE_re_button", 32'(button), 32'hE);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 membrane keypad (Pmod KYPD layout) and debounces it. Produces the 4-bit key code and the level press signal that feed the calculator control unit's `button` / `is_pressed_next` inputs.
- Drives one column low at a time and samples the active-low rows.
- Resolves one key per full scan frame.
- Accepts a press or release only after it is stable for a configurable number of frames.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven; must be >= 4.
- DEBOUNCE_FRAMES, 20: consecutive identical frame results required to accept a change; must be >= 1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- row  in  4  keypad rows; active-low; asynchronous to clock; externally pulled up
- col  out  4  keypad columns; exactly one bit low at any time, the others high
- button  out  4  code of the last accepted key; holds its value after release
- is_pressed  out  1  high while the accepted key is held; connects to the control unit's is_pressed_next
- frame_tick  out  1  one-cycle pulse marking each completed scan frame

Behaviour:
- Reset (reset==0 at a clock edge):
  - col=4'b1110, button=0, is_pressed=0, frame_tick=0.
  - Dwell counter, column index, synchronizer, candidate and stability counter all cleared.
  - Reset mid-frame or mid-debounce discards all partial state; scanning restarts at column 0.
- Input synchronization: row passes through a 2-flop synchronizer. Only the synchronized value is sampled.
- Scan timing:
  - Dwell counter runs 0..SCAN_DIV-1 per column.
  - At count SCAN_DIV-1 the synchronized rows are latched for the current column.
  - On the next edge the column index advances (0->1->2->3->0) and col rotates its low bit.
  - One frame = 4*SCAN_DIV cycles.
- Key map (row r, column c), codes match the control unit's encodings:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Frame evaluation, in the cycle after column 3 is sampled:
  - frame_tick=1 for that cycle.
  - Frame result = NONE (no row low in any column), KEY(code) (exactly one row/column intersection low), or MULTI (two or more).
- Debounce:
  - MULTI: stability counter cleared, candidate unchanged, outputs unchanged.
  - Result equal to candidate: stability counter increments, saturating at DEBOUNCE_FRAMES.
  - Result differs from candidate: candidate takes the new result and the counter is set to 1.
  - Acceptance: when the counter reaches DEBOUNCE_FRAMES, the candidate is applied in the same frame_tick cycle:
    - KEY(k) with is_pressed==0: button=k and is_pressed=1 in the same cycle.
    - KEY(k) with is_pressed==1 and k==button: no change.
    - KEY(k) with is_pressed==1 and k!=button: is_pressed=0 and button=k this cycle; is_pressed=1 on the next cycle. This gives exactly a one-cycle low gap, so the downstream edge detector sees a fresh press.
    - NONE: is_pressed=0; button holds.
  - Outputs change only in frame_tick cycles, plus the one-cycle re-press described above.
- Latency: from a clean, stable press first sampled in frame N, is_pressed rises at the frame_tick ending frame N+DEBOUNCE_FRAMES-1.
- DEBOUNCE_FRAMES=1: every non-MULTI frame is applied immediately.
- Counter widths are sized by $clog2 of the parameters; no overflow is possible.

Test Plan:
Bench settings: SCAN_DIV=4, DEBOUNCE_FRAMES=3, 16-cycle frame. The keypad model pulls row[r] low when key(r,c) is pressed and col[c]==0.
1. Reset held low 5 cycles, then released -> col=1110, button=0, is_pressed=0; col sequence 1110,1101,1011,0111 at 4-cycle steps; frame_tick every 16 cycles.
2. Press key "5" (r1,c1), held 10 frames -> is_pressed rises at the 3rd frame_tick after the first full frame containing the press, with button=4'h5; stays high.
3. Bounce: "7" toggled every 5 cycles for 4 frames, then released -> is_pressed never rises; button stays 0.
4. Hold "A" until accepted, then slide to "C" without release -> 3 frames later is_pressed low for exactly one cycle with button=4'hC, then high.
5. Hold "1" and "2" together for 6 frames -> no output change (MULTI); release "2" -> button=4'h1, is_pressed=1 after 3 frames.
6. Hold "E" accepted, assert reset for one cycle mid-frame -> next cycle button=0, is_pressed=0, col=1110; key re-accepted 3 full frames later.
